// File: rtl/match_seq_ctl.sv
// rtl/match_seq_ctl.sv - Pong match sequencer: serve, rally, point hold, match end
module match_seq_ctl #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start,
  input  logic       abort,
  input  logic       mouse_left,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_reset,
  output logic       ball_en,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  state_t     state;
  logic [7:0] frame_cnt;
  logic       vsync_q;
  logic       mouse_q;
  logic       frame_tick;
  logic       mouse_click;

  assign frame_tick  = vsync_in & ~vsync_q;
  assign mouse_click = mouse_left & ~mouse_q;
  assign state_out   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      frame_cnt   <= 8'd0;
      vsync_q     <= 1'b0;
      mouse_q     <= 1'b0;
      ball_reset  <= 1'b1;
      ball_en     <= 1'b0;
      serve_dir   <= 1'b0;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      winner      <= 2'b00;
    end else begin
      vsync_q <= vsync_in;
      mouse_q <= mouse_left;
      if (frame_tick) frame_cnt <= frame_cnt + 8'd1;

      // Abort overrides everything; scores stay visible in IDLE.
      if (abort) begin
        state      <= IDLE;
        frame_cnt  <= 8'd0;
        ball_reset <= 1'b1;
        ball_en    <= 1'b0;
      end else begin
        case (state)
          IDLE, OVER: begin
            if (start) begin
              state       <= SERVE;
              frame_cnt   <= 8'd0;
              score_left  <= 4'd0;
              score_right <= 4'd0;
              winner      <= 2'b00;
              serve_dir   <= 1'b0;
              ball_reset  <= 1'b1;
              ball_en     <= 1'b0;
            end
          end
          SERVE: begin
            if (mouse_click || (frame_tick && frame_cnt == SERVE_LAST)) begin
              state      <= PLAY;
              frame_cnt  <= 8'd0;
              ball_reset <= 1'b0;
              ball_en    <= 1'b1;
            end
          end
          PLAY: begin
            if (miss_left || miss_right) begin
              state      <= POINT;
              frame_cnt  <= 8'd0;
              ball_reset <= 1'b1;
              ball_en    <= 1'b0;
              // A double miss replays the point without scoring.
              if (miss_left && !miss_right) begin
                serve_dir <= 1'b1;
                if (score_right != WIN) score_right <= score_right + 4'd1;
              end else if (miss_right && !miss_left) begin
                serve_dir <= 1'b0;
                if (score_left != WIN) score_left <= score_left + 4'd1;
              end
            end
          end
          POINT: begin
            if (frame_tick && frame_cnt == POINT_LAST) begin
              frame_cnt <= 8'd0;
              if (score_left == WIN) begin
                winner <= 2'b01;
                state  <= OVER;
              end else if (score_right == WIN) begin
                winner <= 2'b10;
                state  <= OVER;
              end else begin
                state <= SERVE;
              end
            end
          end
          default: begin
            state      <= IDLE;
            frame_cnt  <= 8'd0;
            ball_reset <= 1'b1;
            ball_en    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_match_seq_ctl.sv
// tb/tb_match_seq_ctl.sv - scoreboard bench for match_seq_ctl (WIN_SCORE=2)
module tb_match_seq_ctl;

  logic       clk = 1'b0;
  logic       rst, vsync_in, start, abort, mouse_left, miss_left, miss_right;
  logic       ball_reset, ball_en, serve_dir;
  logic [3:0] score_left, score_right;
  logic [1:0] winner;
  logic [2:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       br;
    logic       be;
    logic       sd;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [1:0] w;
  } exp_t;

  exp_t exp_q[$];

  match_seq_ctl #(.WIN_SCORE(2), .SERVE_FRAMES(60), .POINT_FRAMES(90)) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .start(start), .abort(abort),
    .mouse_left(mouse_left), .miss_left(miss_left), .miss_right(miss_right),
    .ball_reset(ball_reset), .ball_en(ball_en), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right), .winner(winner),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_in = 1'b1; step();
      vsync_in = 1'b0; step();
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] st, input logic br,
                            input logic be, input logic sd, input logic [3:0] sl,
                            input logic [3:0] sr, input logic [1:0] w);
    exp_t e;
    e.tag = tag; e.st = st; e.br = br; e.be = be; e.sd = sd; e.sl = sl; e.sr = sr; e.w = w;
    exp_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = exp_q.pop_front();
    check_val({e.tag, ".state"},  {5'd0, state_out},   {5'd0, e.st});
    check_val({e.tag, ".breset"}, {7'd0, ball_reset},  {7'd0, e.br});
    check_val({e.tag, ".ben"},    {7'd0, ball_en},     {7'd0, e.be});
    check_val({e.tag, ".dir"},    {7'd0, serve_dir},   {7'd0, e.sd});
    check_val({e.tag, ".sl"},     {4'd0, score_left},  {4'd0, e.sl});
    check_val({e.tag, ".sr"},     {4'd0, score_right}, {4'd0, e.sr});
    check_val({e.tag, ".win"},    {6'd0, winner},      {6'd0, e.w});
  endtask

  task automatic click();
    mouse_left = 1'b1; step();
    mouse_left = 1'b0; step();
  endtask

  initial begin
    rst = 1'b1; vsync_in = 0; start = 0; abort = 0; mouse_left = 0; miss_left = 0; miss_right = 0;
    step(); step();
    expect_out("reset", 3'd0, 1, 0, 0, 0, 0, 2'b00); compare_out();
    rst = 1'b0;

    start = 1'b1; step(); start = 1'b0;
    expect_out("start", 3'd1, 1, 0, 0, 0, 0, 2'b00); compare_out();
    frames(59);
    expect_out("serve59", 3'd1, 1, 0, 0, 0, 0, 2'b00); compare_out();
    frames(1);
    expect_out("autolaunch", 3'd2, 0, 1, 0, 0, 0, 2'b00); compare_out();

    miss_left = 1'b1; step(); miss_left = 1'b0;
    expect_out("miss_l", 3'd3, 1, 0, 1, 0, 1, 2'b00); compare_out();
    frames(89);
    expect_out("point89", 3'd3, 1, 0, 1, 0, 1, 2'b00); compare_out();
    frames(1);
    expect_out("point_end", 3'd1, 1, 0, 1, 0, 1, 2'b00); compare_out();

    frames(3);
    mouse_left = 1'b1; step();
    expect_out("click", 3'd2, 0, 1, 1, 0, 1, 2'b00); compare_out();
    step(); step(); step();
    expect_out("held_mouse", 3'd2, 0, 1, 1, 0, 1, 2'b00); compare_out();
    mouse_left = 1'b0; step();

    miss_left = 1'b1; miss_right = 1'b1; step(); miss_left = 1'b0; miss_right = 1'b0;
    expect_out("double_miss", 3'd3, 1, 0, 1, 0, 1, 2'b00); compare_out();
    start = 1'b1; frames(90); start = 1'b0;
    expect_out("replay_serve", 3'd1, 1, 0, 1, 0, 1, 2'b00); compare_out();
    click();
    miss_left = 1'b1; step(); miss_left = 1'b0;
    expect_out("miss_l2", 3'd3, 1, 0, 1, 0, 2, 2'b00); compare_out();
    frames(90);
    expect_out("over", 3'd4, 1, 0, 1, 0, 2, 2'b10); compare_out();
    miss_right = 1'b1; step(); miss_right = 1'b0;
    mouse_left = 1'b1; step(); mouse_left = 1'b0; step();
    expect_out("over_ignore", 3'd4, 1, 0, 1, 0, 2, 2'b10); compare_out();
    start = 1'b1; step(); start = 1'b0;
    expect_out("restart", 3'd1, 1, 0, 0, 0, 0, 2'b00); compare_out();

    click();
    miss_right = 1'b1; step(); miss_right = 1'b0;
    expect_out("miss_r", 3'd3, 1, 0, 0, 1, 0, 2'b00); compare_out();
    frames(90);
    click();
    expect_out("play3", 3'd2, 0, 1, 0, 1, 0, 2'b00); compare_out();
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    expect_out("abort", 3'd0, 1, 0, 0, 1, 0, 2'b00); compare_out();

    start = 1'b1; step(); start = 1'b0;
    click();
    miss_left = 1'b1; step(); miss_left = 1'b0;
    frames(45);
    expect_out("pre_rst", 3'd3, 1, 0, 1, 0, 1, 2'b00); compare_out();
    rst = 1'b1; step(); rst = 1'b0;
    expect_out("mid_rst", 3'd0, 1, 0, 0, 0, 0, 2'b00); compare_out();
    frames(60);
    expect_out("idle_stays", 3'd0, 1, 0, 0, 0, 0, 2'b00); compare_out();

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
